y86_bus_mem: RTL

Byte-addressed program/data memory that sits directly on the y86 sequential core's bus, downstream of its `bus_A`/`bus_out`/`bus_WE`/`bus_RE` outputs, and produces its `bus_in`. It also contains a boot-loader FSM. The FSM fills the memory from a byte stream while holding the core in reset, then releases it. Reads are combinational little-endian 32-bit words at any byte address, matching the core's same-edge sampling of `bus_in`. Writes are synchronous 32-bit.

---
 rtl/y86_pkg.sv | 21 ++
 rtl/y86_byte_ram.sv | 41 ++++
 rtl/y86_bus_mem.sv | 107 ++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the y86 core and its bus memory: loader states,
// data widths and the opcode values the core decodes.
package y86_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } mem_state_t;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h29;
    localparam logic [7:0] OP_MOV  = 8'h89;
    localparam logic [7:0] OP_LOAD = 8'h8B;
    localparam logic [7:0] OP_JNZ  = 8'h75;
    localparam logic [7:0] OP_HLT  = 8'hF4;

endpackage

// File: rtl/y86_byte_ram.sv
// Byte-wide storage with a 4-byte little-endian combinational read window,
// a 4-byte synchronous write window and a single-byte loader write port.
module y86_byte_ram
    import y86_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [BYTE_W-1:0] ld_data
);

    // Contents are deliberately not reset; the boot loader defines them.
    logic [BYTE_W-1:0] mem [0:(2**ADDR_W)-1];

    // Byte lanes wrap at the top of the array because the index sum is ADDR_W wide.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            rd_data[BYTE_W*i +: BYTE_W] = mem[rd_addr + ADDR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                mem[wr_addr + ADDR_W'(i)] <= wr_data[BYTE_W*i +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/y86_bus_mem.sv
// Bus-attached program/data memory for the y86 core, with a boot loader that
// fills memory from a byte stream while holding the core in reset.
module y86_bus_mem
    import y86_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int REL_DLY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] bus_A,
    input  logic [WORD_W-1:0] bus_out,
    input  logic              bus_WE,
    input  logic              bus_RE,
    output logic [WORD_W-1:0] bus_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [BYTE_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_rst,
    output logic              bus_err
);

    localparam int CNT_W = (REL_DLY > 2) ? $clog2(REL_DLY) : 1;
    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    // Loader state is kept as a plainly named signal so checkers can bind to it.
    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  rel_cnt;
    logic              ld_fire;
    logic              core_we;
    logic [WORD_W-1:0] rd_word;
    logic [ADDR_W-1:0] addr;
    logic              unused_addr_hi;

    assign addr           = bus_A[ADDR_W-1:0];
    assign unused_addr_hi = ^bus_A[WORD_W-1:ADDR_W];

    // ld_valid/ld_ready: a byte moves on every rising edge where both are high;
    // the source may hold or drop ld_valid at will and nothing is lost.
    always_comb begin
        state_nxt = state;
        ld_ready  = 1'b0;
        cpu_rst   = 1'b1;
        case (state)
            LOAD: begin
                ld_ready = rst;
                if (ld_valid && rst && (ld_last || ptr == PTR_MAX)) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (rel_cnt == '0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                cpu_rst = 1'b0;
            end
            default: state_nxt = LOAD;
        endcase
    end

    assign ld_fire = ld_valid && ld_ready;
    assign core_we = (state == RUN) && bus_WE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= LOAD;
            ptr     <= '0;
            rel_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld_fire) begin
                ptr <= ptr + 1'b1;
            end
            if (state == LOAD && state_nxt == RELEASE) begin
                rel_cnt <= CNT_W'(REL_DLY - 1);
            end else if (state == RELEASE && rel_cnt != '0) begin
                rel_cnt <= rel_cnt - 1'b1;
            end
            if (state == RUN && bus_WE && bus_RE) begin
                bus_err <= 1'b1;
            end
        end
    end

    y86_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rd_addr (addr),
        .rd_data (rd_word),
        .wr_en   (core_we),
        .wr_addr (addr),
        .wr_data (bus_out),
        .ld_en   (ld_fire),
        .ld_addr (ptr),
        .ld_data (ld_data)
    );

    assign bus_in = bus_RE ? rd_word : '0;

endmodule
